// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues pipelined imem reads, queues {pc,instr}; FETCH_PERF_CNT_EN adds perf counters.
// Latency: first out_valid 2 cycles after reset/redirect with a 1-cycle grant-to-rvalid memory.
// Backpressure: out_ready low fills the queue; requests stop once queued + in-flight words reach DEPTH.
module fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic          accept;
    logic          push;
    logic          pop;
    logic          rsp_drop;

    assign imem_addr = {fetch_pc[31:2], 2'b00};

    always_comb begin
        // Reserving queue space for every in-flight word means a push can never overflow.
        imem_req  = !reset && !redirect_valid
                    && ((int'(count) + int'(outstanding)) < DEPTH)
                    && (int'(outstanding) < MAX_OUTSTANDING);
        out_valid = (count != '0) && !redirect_valid;
        out_instr = (count != '0) ? q_instr[rd_ptr] : 32'd0;
        out_pc    = (count != '0) ? q_pc[rd_ptr]    : 32'd0;
        accept    = imem_req && imem_gnt;
        rsp_drop  = imem_rvalid && (redirect_valid || (discard != '0));
        push      = imem_rvalid && !rsp_drop;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            resp_pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case ({accept, imem_rvalid})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - OW'(imem_rvalid);
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end else if (imem_rvalid) begin
                    discard <= discard - OW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect_valid) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_dropped <= perf_dropped + 32'(rsp_drop)
                            + (redirect_valid ? 32'(count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory with configurable latency plus an epoch-tagged reference queue.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    int          checks = 0;
    int          failures = 0;
    mreq_t       mq[$];
    ent_t        q[$];
    logic [31:0] pops[$];
    mreq_t       cur;
    ent_t        e;
    int          epoch = 0;
    int          tb_out = 0;
    int          cyc = 0;
    logic [31:0] exp_fpc = 32'h0;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_dropped = 0;
    int          k_gnt = 100, k_lat = 1, k_rdy = 100, k_redir = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        last_ov, last_req;
    logic [31:0] last_addr;
    logic        rv;
    int          n;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_f", perf_fetched, 0);
        chk("rst_perf_d", perf_dropped, 0);
`endif
        mq.delete(); q.delete();
        tb_out = 0; cyc = 0; epoch++;
        exp_fpc = 32'h0; prev_pend = 1'b0;
        m_fetched = 0; m_dropped = 0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        imem_gnt = ($urandom_range(99) < k_gnt);
        rv = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            cur = mq.pop_front();
        end
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(cur.addr) : $urandom;
        redirect_valid = force_redir || ($urandom_range(99) < k_redir);
        redirect_pc    = force_redir ? force_pc : $urandom;
        out_ready      = ($urandom_range(99) < k_rdy);
        #1;
        last_ov = out_valid; last_req = imem_req; last_addr = imem_addr;

        chk("out_valid", out_valid, (!redirect_valid && q.size() != 0));
        chk("imem_req", imem_req,
            (!redirect_valid && (q.size() + tb_out < DEPTH) && (tb_out < MAXO)));
        chk("imem_addr", imem_addr, exp_fpc);
        if (prev_pend && !redirect_valid) chk("addr_hold", imem_addr, prev_addr);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_dropped", perf_dropped, m_dropped);
`endif
        if (out_valid && out_ready) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.ins);
                pops.push_back(out_pc);
                m_fetched++;
            end
        end else if (!out_valid && !redirect_valid) begin
            chk("empty_pc", out_pc, 0);
            chk("empty_instr", out_instr, 0);
        end

        // Reference update for the coming clock edge.
        if (imem_req && imem_gnt) begin
            mq.push_back('{addr: imem_addr, due: cyc + k_lat, epoch: epoch});
            tb_out++;
            exp_fpc = exp_fpc + 32'd4;
        end
        if (rv) begin
            tb_out--;
            if (redirect_valid || cur.epoch != epoch) m_dropped++;
            else q.push_back('{pc: cur.addr, ins: mem_word(cur.addr)});
        end
        if (redirect_valid) begin
            m_dropped = m_dropped + q.size();
            q.delete();
            epoch++;
            exp_fpc = {redirect_pc[31:2], 2'b00};
        end
        prev_pend = imem_req && !imem_gnt;
        prev_addr = imem_addr;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

        // Streaming start-up: 2-cycle latency then one instruction per cycle.
        do_reset();
        k_gnt = 100; k_lat = 1; k_rdy = 100; k_redir = 0;
        pops.delete();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("startup_ov", last_ov, (i >= 2));
            chk("req_steady", last_req, 1);
        end
        chk("stream_pc0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h0);
        chk("stream_pc5", (pops.size() > 5) ? pops[5] : 32'hDEAD_BEEF, 32'h14);

        // Backpressure: queue fills, request stops at 0x10.
        do_reset();
        k_rdy = 0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_req", last_req, 0);
        chk("bp_addr", last_addr, 32'h10);
        chk("bp_qfull", q.size(), DEPTH);
        pops.delete();
        k_rdy = 100;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 5; i++)
            chk("bp_order", (pops.size() > i) ? pops[i] : 32'hDEAD_BEEF, 32'(i * 4));

        // Stalling grants with slow memory.
        k_gnt = 50; k_lat = 3; k_rdy = 70;
        for (int i = 0; i < 200; i++) begin
            step();
            chk("outstanding_max", (tb_out <= MAXO), 1);
        end

        // Redirect with words queued and requests in flight.
        do_reset();
        k_gnt = 100; k_lat = 3; k_rdy = 0;
        n = 0;
        while (!(tb_out == MAXO && q.size() >= 2) && n < 40) begin
            step();
            n++;
        end
        chk("redir_setup", (n < 40), 1);
        pops.delete();
        force_redir = 1'b1; force_pc = 32'h200;
        step();
        chk("redir_ov", last_ov, 0);
        force_redir = 1'b0; k_rdy = 100;
        for (int i = 0; i < 20; i++) step();
        chk("redir_pc0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h200);
        chk("redir_pc1", (pops.size() > 1) ? pops[1] : 32'hDEAD_BEEF, 32'h204);

        // Redirect on a response cycle, immediately followed by another.
        k_lat = 2;
        n = 0;
        while (!(mq.size() > 0 && mq[0].due == cyc) && n < 20) begin
            step();
            n++;
        end
        chk("dbl_setup", (n < 20), 1);
        pops.delete();
        force_redir = 1'b1; force_pc = 32'h100;
        step();
        force_pc = 32'h300;
        step();
        force_redir = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("dbl_pc0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h300);

        // PC wrap with a full queue draining while refilling.
        k_lat = 1; k_rdy = 0;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        step();
        force_redir = 1'b0;
        n = 0;
        while (q.size() != DEPTH && n < 20) begin
            step();
            n++;
        end
        chk("wrap_full", (n < 20), 1);
        pops.delete();
        k_rdy = 100;
        for (int i = 0; i < 10; i++) step();
        chk("wrap_pc0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap_pc1", (pops.size() > 1) ? pops[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_pc2", (pops.size() > 2) ? pops[2] : 32'hDEAD_BEEF, 32'h0);

        // Mixed random traffic with redirects and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                k_gnt   = $urandom_range(30, 100);
                k_lat   = $urandom_range(1, 4);
                k_rdy   = $urandom_range(20, 100);
                k_redir = $urandom_range(0, 8);
            end
            if (i == 200) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
